decoder_n_pipe: RTL and testbench
=================================

// Module: decoder_n_pipe
// PURPOSE
//  Parametrised, registered SEL_W-to-2^SEL_W decoder with a valid/ready handshake on both sides.
//  Three output modes: one-hot, thermometer, and sweep. Sweep emits the one-hot codes 0..sel
//  as a multi-beat burst.
//  Drives select/strobe fan-out (bank enables, scan strobes) from a pipelined control path.
//  Generalises the 2-4 enable decoder: code bit0 is the LSB; out[k]=1 iff en=1 and code==k.
// PARAMETERS
//  SEL_W   2   width of select code; OUT_W = 1<<SEL_W (localparam, not overridable)
//  INV_OUT 0   1 = out_data driven active-low (bitwise inverted at the register output)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      input beat offered
//  in_ready   out  1      block can accept a beat this cycle
//  sel        in   SEL_W  code to decode, sampled on accept only
//  en         in   1      decode enable, sampled on accept; 0 -> all-inactive output word
//  mode       in   2      00 one-hot, 01 thermometer, 10 sweep, 11 = treated as one-hot
//  out_valid  out  1      out_data/out_code/out_last valid
//  out_ready  in   1      downstream accepts the beat
//  out_data   out  OUT_W  decoded word
//  out_code   out  SEL_W  index of the code currently presented (sel, or sweep count)
//  out_last   out  1      last beat of a transfer (always 1 outside sweep)
// BEHAVIOUR
//  - Accept: in_valid && in_ready. Output handshake: out_valid && out_ready.
//  - Reset, async on rst=1: state=EMPTY, out_valid=0, out_last=0, out_code=0, count=0.
//    out_data is all-inactive: 0, or all-ones when INV_OUT=1.
//    Any in-flight sweep is aborted and never resumes. in_ready is 1 after rst is released.
//  - States:
//    EMPTY  out_valid=0
//    FULL   one word held
//    SWEEP  burst in progress, not on its last beat
//  - in_ready = (state==EMPTY) || (state==FULL && out_ready). It is combinational.
//    in_ready = 0 in SWEEP.
//  - Latency: a beat accepted in cycle t is presented with out_valid=1 from cycle t+1.
//    Back-to-back accept and release at full rate is supported with no bubble.
//  - Decoding of an accepted beat (active-high view; INV_OUT inverts out_data only):
//    en=0                  -> out_data=0, out_code=sel, out_last=1, state FULL, any mode
//    one-hot/11            -> out_data[k]=(k==sel), out_last=1, FULL
//    thermometer           -> out_data[k]=(k<=sel), out_last=1, FULL
//    sweep, sel==0         -> out_data=onehot(0), out_code=0, out_last=1, FULL
//    sweep, sel>0          -> out_data=onehot(0), out_code=0, count=0, target=sel,
//                             out_last=0, SWEEP
//  - SWEEP on out_ready=1: count++, out_data=onehot(count+1), out_code=count+1.
//    When count+1==target: out_last=1 and go to FULL. Sweep length is sel+1 beats.
//  - FULL on out_ready=1 with no accept -> EMPTY. FULL on out_ready=1 with accept -> reload.
//  - Backpressure (out_ready=0): out_data, out_code and out_last are held stable.
//    out_valid stays 1 until the output handshake.
//  - sel/en/mode changes while not accepting are ignored. count/target are SEL_W wide.
//    Max target 2^SEL_W-1 does not overflow count.
//  - out_valid never drops without an output handshake, except on rst.
// TESTING (SEL_W=2 unless noted, INV_OUT=0, out_ready=1 unless noted)
//  1 one-hot: sel=2,en=1,mode=00 accepted at t -> t+1 out_data=4'b0100, out_code=2, out_last=1.
//    Run with SEL_W=3, all 8 codes -> 8'b1 << sel.
//  2 enable/thermo: en=0,sel=3 -> 4'b0000. mode=01 with sel=2 -> 4'b0111; sel=0 -> 4'b0001.
//  3 sweep: sel=3,mode=10 -> 0001,0010,0100,1000 on 4 consecutive cycles, out_code=0..3.
//    out_last=1 only on 1000. in_ready=0 for the first 3 beats and 1 on the last beat.
//    A next beat offered then is accepted with no bubble.
//  4 backpressure: out_ready=0 for 3 cycles mid-sweep at 0010 -> word held, in_ready=0.
//    Resumes with 0100 after out_ready=1.
//  5 reset: rst pulsed asynchronously after the second sweep beat -> out_valid=0 and
//    out_data=0 immediately, without a clock edge. A new sweep after release starts at 0001.
//  6 INV_OUT=1, sel=1 one-hot -> out_data=4'b1101. Reset value is 4'b1111.

Source files
------------

// File: rtl/decoder_n_pipe_if.sv
// Handshake bundle for decoder_n_pipe: one input beat channel and one decoded output channel.
// master drives the request side and out_ready; slave is the decoder.
interface decoder_n_pipe_if #(
    parameter int SEL_W = 2
);
    localparam int OUT_W = 1 << SEL_W;

    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [SEL_W-1:0] out_code;
    logic             out_last;

    modport master (
        output in_valid, sel, en, mode, out_ready,
        input  in_ready, out_valid, out_data, out_code, out_last
    );

    modport slave (
        input  in_valid, sel, en, mode, out_ready,
        output in_ready, out_valid, out_data, out_code, out_last
    );
endinterface

// File: rtl/decoder_n_pipe.sv
// Registered SEL_W-to-2^SEL_W decoder (one-hot, thermometer, sweep burst) with valid/ready on both sides.
// The output word is held internally active-high and inverted only at the port when INV_OUT=1.
module decoder_n_pipe #(
    parameter int SEL_W   = 2,
    parameter bit INV_OUT = 1'b0
) (
    input logic               clk,
    input logic               rst,
    decoder_n_pipe_if.slave   dec_bus
);
    localparam int OUT_W = 1 << SEL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [SEL_W-1:0] code_q, code_d;
    logic             last_q, last_d;
    logic [SEL_W-1:0] count_q, count_d;
    logic [SEL_W-1:0] target_q, target_d;

    logic             in_ready;
    logic             accept;
    logic [SEL_W-1:0] count_inc;
    logic [OUT_W-1:0] onehot_sel;
    logic [OUT_W-1:0] thermo_sel;
    logic [OUT_W-1:0] onehot_next;

    assign count_inc = count_q + SEL_W'(1);

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
            assign onehot_sel[gi]  = (SEL_W'(gi) == dec_bus.sel);
            assign thermo_sel[gi]  = (SEL_W'(gi) <= dec_bus.sel);
            assign onehot_next[gi] = (SEL_W'(gi) == count_inc);
        end
    endgenerate

    // A FULL stage can take a new beat in the same cycle its word leaves; SWEEP never can.
    assign in_ready = (state_q == EMPTY) || ((state_q == FULL) && dec_bus.out_ready);
    assign accept   = dec_bus.in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        code_d   = code_q;
        last_d   = last_q;
        count_d  = count_q;
        target_d = target_q;
        case (state_q)
            EMPTY, FULL: begin
                if (accept) begin
                    code_d   = dec_bus.sel;
                    count_d  = '0;
                    target_d = dec_bus.sel;
                    last_d   = 1'b1;
                    state_d  = FULL;
                    if (!dec_bus.en) begin
                        data_d = '0;
                    end else begin
                        case (dec_bus.mode)
                            2'b01: data_d = thermo_sel;
                            2'b10: begin
                                data_d = OUT_W'(1);
                                code_d = '0;
                                if (dec_bus.sel != '0) begin
                                    last_d  = 1'b0;
                                    state_d = SWEEP;
                                end
                            end
                            default: data_d = onehot_sel;
                        endcase
                    end
                end else if ((state_q == FULL) && dec_bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            SWEEP: begin
                if (dec_bus.out_ready) begin
                    count_d = count_inc;
                    data_d  = onehot_next;
                    code_d  = count_inc;
                    if (count_inc == target_q) begin
                        last_d  = 1'b1;
                        state_d = FULL;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            code_q   <= '0;
            last_q   <= 1'b0;
            count_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            code_q   <= code_d;
            last_q   <= last_d;
            count_q  <= count_d;
            target_q <= target_d;
        end
    end

    assign dec_bus.in_ready  = in_ready;
    assign dec_bus.out_valid = (state_q != EMPTY);
    assign dec_bus.out_data  = INV_OUT ? ~data_q : data_q;
    assign dec_bus.out_code  = code_q;
    assign dec_bus.out_last  = last_q;
endmodule

// File: tb/tb_decoder_n_pipe.sv
// Bench for decoder_n_pipe: a queue-of-beats reference model checked against the SEL_W=2 instance,
// plus directed checks on SEL_W=3 and INV_OUT=1 instances.
module tb_decoder_n_pipe;
    logic clk;
    logic rst;

    decoder_n_pipe_if #(.SEL_W(2)) bus2 ();
    decoder_n_pipe_if #(.SEL_W(3)) bus3 ();
    decoder_n_pipe_if #(.SEL_W(2)) businv ();

    decoder_n_pipe #(.SEL_W(2), .INV_OUT(1'b0)) dut2 (.clk(clk), .rst(rst), .dec_bus(bus2));
    decoder_n_pipe #(.SEL_W(3), .INV_OUT(1'b0)) dut3 (.clk(clk), .rst(rst), .dec_bus(bus3));
    decoder_n_pipe #(.SEL_W(2), .INV_OUT(1'b1)) dutinv (.clk(clk), .rst(rst), .dec_bus(businv));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] data;
        logic [1:0] code;
        logic       last;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: every accepted request expands into the list of beats it will emit.
    task automatic push_beats(input logic [1:0] s, input logic e, input logic [1:0] m);
        beat_t b;
        int    v;
        if (!e) begin
            b.data = 4'h0; b.code = s; b.last = 1'b1; q.push_back(b);
        end else if (m == 2'b10) begin
            for (int i = 0; i <= int'(s); i++) begin
                v = 1 << i;
                b.data = v[3:0]; b.code = 2'(i); b.last = (i == int'(s)); q.push_back(b);
            end
        end else if (m == 2'b01) begin
            v = (1 << (int'(s) + 1)) - 1;
            b.data = v[3:0]; b.code = s; b.last = 1'b1; q.push_back(b);
        end else begin
            v = 1 << int'(s);
            b.data = v[3:0]; b.code = s; b.last = 1'b1; q.push_back(b);
        end
    endtask

    // One cycle on the SEL_W=2 instance; called at posedge+1, returns at next posedge+1.
    task automatic step(input logic iv, input logic [1:0] s, input logic e,
                        input logic [1:0] m, input logic ordy);
        logic exp_rdy;
        logic acc;
        logic hs;
        bus2.in_valid  = iv;
        bus2.sel       = s;
        bus2.en        = e;
        bus2.mode      = m;
        bus2.out_ready = ordy;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
        @(negedge clk);
        check("in_ready", 32'(bus2.in_ready), 32'(exp_rdy));
        check("out_valid", 32'(bus2.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_data", 32'(bus2.out_data), 32'(q[0].data));
            check("out_code", 32'(bus2.out_code), 32'(q[0].code));
            check("out_last", 32'(bus2.out_last), 32'(q[0].last));
        end
        acc = iv && exp_rdy;
        hs  = (q.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (hs) void'(q.pop_front());
        if (acc) begin
            push_beats(s, e, m);
            $display("txn accept sel=%0d en=%0d mode=%0d beats_queued=%0d", s, e, m, q.size());
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
    endtask

    initial begin
        logic [7:0] exp8;
        rst = 1'b0;
        bus2.in_valid = 0; bus2.sel = 0; bus2.en = 0; bus2.mode = 0; bus2.out_ready = 0;
        bus3.in_valid = 0; bus3.sel = 0; bus3.en = 0; bus3.mode = 0; bus3.out_ready = 0;
        businv.in_valid = 0; businv.sel = 0; businv.en = 0; businv.mode = 0; businv.out_ready = 0;
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 32'(bus2.out_valid), 32'd0);
        check("rst_data", 32'(bus2.out_data), 32'd0);
        check("rst_code", 32'(bus2.out_code), 32'd0);
        check("rst_last", 32'(bus2.out_last), 32'd0);
        check("rst_inv_data", 32'(businv.out_data), 32'hF);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // one-hot, enable-off, thermometer
        step(1'b1, 2'd2, 1'b1, 2'b00, 1'b1);
        step(1'b1, 2'd3, 1'b0, 2'b00, 1'b1);
        step(1'b1, 2'd2, 1'b1, 2'b01, 1'b1);
        step(1'b1, 2'd0, 1'b1, 2'b01, 1'b1);
        step(1'b1, 2'd1, 1'b1, 2'b11, 1'b1);
        drain();

        // sweep sel=3 with the next request offered continuously
        step(1'b1, 2'd3, 1'b1, 2'b10, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 1'b1, 2'b00, 1'b1);
        drain();

        // backpressure mid-sweep at 0010
        step(1'b1, 2'd3, 1'b1, 2'b10, 1'b1);
        step(1'b0, 2'd0, 1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 1'b1, 2'b00, 1'b0);
        drain();

        // async reset after the second sweep beat, then a fresh sweep
        step(1'b1, 2'd3, 1'b1, 2'b10, 1'b1);
        step(1'b0, 2'd0, 1'b1, 2'b00, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus2.out_valid), 32'd0);
        check("arst_data", 32'(bus2.out_data), 32'd0);
        check("arst_last", 32'(bus2.out_last), 32'd0);
        check("arst_code", 32'(bus2.out_code), 32'd0);
        #1 rst = 1'b0;
        q.delete();
        step(1'b1, 2'd2, 1'b1, 2'b10, 1'b1);
        drain();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom), ($urandom_range(0, 7) != 0),
                 2'($urandom), ($urandom_range(0, 3) != 0));
        end
        drain();

        // SEL_W=3: all eight codes one-hot
        bus3.out_ready = 1'b1;
        bus3.en = 1'b1;
        bus3.mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            bus3.in_valid = 1'b1;
            bus3.sel = 3'(i);
            @(posedge clk);
            #1 bus3.in_valid = 1'b0;
            @(negedge clk);
            exp8 = 8'd1 << i;
            check("w3_valid", 32'(bus3.out_valid), 32'd1);
            check("w3_data", 32'(bus3.out_data), 32'(exp8));
            check("w3_code", 32'(bus3.out_code), 32'(i));
            $display("txn w3 sel=%0d out=%b", i, bus3.out_data);
        end

        // INV_OUT=1: sel=1 one-hot, then enable off
        businv.out_ready = 1'b1;
        businv.en = 1'b1;
        businv.mode = 2'b00;
        businv.sel = 2'd1;
        businv.in_valid = 1'b1;
        @(posedge clk);
        #1 businv.en = 1'b0;
        @(negedge clk);
        check("inv_onehot", 32'(businv.out_data), 32'hD);
        @(posedge clk);
        #1 businv.in_valid = 1'b0;
        @(negedge clk);
        check("inv_en0", 32'(businv.out_data), 32'hF);
        $display("txn inv done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule
